// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared definitions for the PS/2 key-state tracker and its consumers.
//   NUM_KEYS        width of the key-state vector
//   KEY_*           fixed key index map (mode keys plus piano keys)
//   SC_*            PS/2 set-2 scancodes, including the F0/E0 prefixes and the AA BAT code
//   rx_state_e      frame receiver state encoding
//   key_lookup()    scancode -> {hit, index}
package ps2_key_pkg;

    localparam int unsigned NUM_KEYS  = 16;
    localparam int unsigned KEY_IDX_W = $clog2(NUM_KEYS);

    // Key index map, shared with the mode FSM and the note generator
    localparam int unsigned KEY_SPACE = 0;
    localparam int unsigned KEY_ENTER = 1;
    localparam int unsigned KEY_R     = 2;
    localparam int unsigned KEY_A     = 3;
    localparam int unsigned KEY_W     = 4;
    localparam int unsigned KEY_S     = 5;
    localparam int unsigned KEY_E     = 6;
    localparam int unsigned KEY_D     = 7;
    localparam int unsigned KEY_F     = 8;
    localparam int unsigned KEY_T     = 9;
    localparam int unsigned KEY_G     = 10;
    localparam int unsigned KEY_Y     = 11;
    localparam int unsigned KEY_H     = 12;
    localparam int unsigned KEY_U     = 13;
    localparam int unsigned KEY_J     = 14;
    localparam int unsigned KEY_K     = 15;

    // Scancodes (set 2)
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_E      = 8'h24;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_T      = 8'h2C;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_Y      = 8'h35;
    localparam logic [7:0] SC_H      = 8'h33;
    localparam logic [7:0] SC_U      = 8'h3C;
    localparam logic [7:0] SC_J      = 8'h3B;
    localparam logic [7:0] SC_K      = 8'h42;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;

    typedef enum logic [1:0] {
        RxIdle,
        RxData,
        RxParity,
        RxStop
    } rx_state_e;

    typedef struct packed {
        logic                 hit;
        logic [KEY_IDX_W-1:0] idx;
    } key_lookup_t;

    function automatic key_lookup_t key_lookup(input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.idx = '0;
        case (code)
            SC_SPACE: r.idx = KEY_IDX_W'(KEY_SPACE);
            SC_ENTER: r.idx = KEY_IDX_W'(KEY_ENTER);
            SC_R:     r.idx = KEY_IDX_W'(KEY_R);
            SC_A:     r.idx = KEY_IDX_W'(KEY_A);
            SC_W:     r.idx = KEY_IDX_W'(KEY_W);
            SC_S:     r.idx = KEY_IDX_W'(KEY_S);
            SC_E:     r.idx = KEY_IDX_W'(KEY_E);
            SC_D:     r.idx = KEY_IDX_W'(KEY_D);
            SC_F:     r.idx = KEY_IDX_W'(KEY_F);
            SC_T:     r.idx = KEY_IDX_W'(KEY_T);
            SC_G:     r.idx = KEY_IDX_W'(KEY_G);
            SC_Y:     r.idx = KEY_IDX_W'(KEY_Y);
            SC_H:     r.idx = KEY_IDX_W'(KEY_H);
            SC_U:     r.idx = KEY_IDX_W'(KEY_U);
            SC_J:     r.idx = KEY_IDX_W'(KEY_J);
            SC_K:     r.idx = KEY_IDX_W'(KEY_K);
            default:  r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
// Synchronises the raw pins, detects ps2_clk falling edges and assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop). A frame stalled
// mid-way for TIMEOUT_CYCLES clk cycles is aborted.
// Ports:
//   clk, resetn       system clock, synchronous active-low reset
//   ps2_clk_i         raw PS/2 clock pin (asynchronous)
//   ps2_dat_i         raw PS/2 data pin (asynchronous)
//   byte_o            last valid data byte
//   byte_valid_o      one-cycle strobe, byte_o is valid
//   frame_error_o     one-cycle pulse on parity, stop-bit or timeout error
module ps2_frame_rx
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_error_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync_q;
    logic [1:0]      dat_sync_q;
    logic            clk_prev_q;
    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_error_q, frame_error_d;

    logic fall_edge;
    logic dat;

    assign fall_edge = clk_prev_q & ~clk_sync_q[1];
    assign dat       = dat_sync_q[1];

    // Synchronisers idle high, matching the released PS/2 bus.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= RxIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tmo_cnt_q     <= '0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tmo_cnt_q     <= tmo_cnt_d;
            byte_q        <= byte_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        byte_d        = byte_q;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        if (state_q == RxIdle || fall_edge) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end

        unique case (state_q)
            RxIdle: begin
                // A high start bit is line noise: stay idle silently.
                if (fall_edge && !dat) begin
                    state_d   = RxData;
                    bit_cnt_d = '0;
                end
            end
            RxData: begin
                if (fall_edge) begin
                    shift_d   = {dat, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RxParity;
                    end
                end
            end
            RxParity: begin
                if (fall_edge) begin
                    parity_d = dat;
                    state_d  = RxStop;
                end
            end
            RxStop: begin
                if (fall_edge) begin
                    state_d = RxIdle;
                    if (dat && (^{shift_q, parity_q})) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: state_d = RxIdle;
        endcase

        // Stalled frame: abandon it so the next start bit is seen cleanly.
        if (state_q != RxIdle && !fall_edge && tmo_cnt_q == TmoLast) begin
            state_d       = RxIdle;
            frame_error_d = 1'b1;
            tmo_cnt_d     = '0;
        end
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = byte_valid_q;
    assign frame_error_o = frame_error_q;

endmodule

// File: rtl/ps2_key_state_tracker.sv
// ps2_key_state_tracker: decodes PS/2 make/break/extended scancodes into a
// live pressed/released vector for the tracked keys (index map in ps2_key_pkg).
// Optional build macro PS2_HOTPLUG_CLEAR_EN: a valid unprefixed 0xAA
// (keyboard BAT complete) clears every key_state bit without press pulses.
// Ports:
//   clk, resetn       system clock, synchronous active-low reset
//   ps2_clk_i         raw PS/2 clock pin (asynchronous)
//   ps2_dat_i         raw PS/2 data pin (asynchronous)
//   key_state_o       1 = key currently held
//   key_pressed_o     one-cycle pulse on a key's 0->1 transition
//   frame_error_o     one-cycle pulse on parity, stop-bit or timeout error
module ps2_key_state_tracker
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ps2_clk_i,
    input  logic                ps2_dat_i,
    output logic [NUM_KEYS-1:0] key_state_o,
    output logic [NUM_KEYS-1:0] key_pressed_o,
    output logic                frame_error_o
);

    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_error;
    key_lookup_t lk;

    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] key_pressed_q, key_pressed_d;
    logic                break_q, break_d;
    logic                ext_q, ext_d;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk          (clk),
        .resetn       (resetn),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_dat_i    (ps2_dat_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_error_o(rx_error)
    );

    assign lk = key_lookup(rx_byte);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_state_q   <= '0;
            key_pressed_q <= '0;
            break_q       <= 1'b0;
            ext_q         <= 1'b0;
        end else begin
            key_state_q   <= key_state_d;
            key_pressed_q <= key_pressed_d;
            break_q       <= break_d;
            ext_q         <= ext_d;
        end
    end

    // Erroneous frames never strobe rx_valid, so prefixes survive them.
    always_comb begin
        key_state_d = key_state_q;
        break_d     = break_q;
        ext_d       = ext_q;

        if (rx_valid) begin
            if (rx_byte == SC_BREAK) begin
                break_d = 1'b1;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                // Extended codes (e.g. keypad Enter E0 5A) alias tracked keys: drop them.
                if (!ext_q && lk.hit) begin
                    key_state_d[lk.idx] = ~break_q;
                end
`ifdef PS2_HOTPLUG_CLEAR_EN
                if (!ext_q && !break_q && rx_byte == SC_BAT_OK) begin
                    key_state_d = '0;
                end
`endif
                break_d = 1'b0;
                ext_d   = 1'b0;
            end
        end

        // Only genuine 0->1 transitions pulse; typematic repeats leave state at 1.
        key_pressed_d = key_state_d & ~key_state_q;
    end

    assign key_state_o   = key_state_q;
    assign key_pressed_o = key_pressed_q;
    assign frame_error_o = rx_error;

endmodule
